// File: rtl/gameover_lives_controller_if.sv
// rtl/gameover_lives_controller_if.sv - pixel-side bundle between renderers, banner ROM and the lives controller
interface gameover_lives_controller_if #(
  parameter int NUM_OBJ = 4,
  parameter int HRES    = 1280
);
  logic                     fsync;
  logic [NUM_OBJ-1:0]       active_obj;
  logic                     active_paddle;
  logic signed [11:0]       hpos;
  logic signed [11:0]       vpos;
  logic [HRES-1:0]          banner_row;
  logic [7:0]               banner_addr;
  logic [3:0]               lives;
  logic [1:0]               state;
  logic                     game_over;
  logic                     use_overlay;
  logic [7:0]               pixel_overlay [3];

  modport master (
    output fsync, active_obj, active_paddle, hpos, vpos, banner_row,
    input  banner_addr, lives, state, game_over, use_overlay, pixel_overlay
  );

  modport slave (
    input  fsync, active_obj, active_paddle, hpos, vpos, banner_row,
    output banner_addr, lives, state, game_over, use_overlay, pixel_overlay
  );
endinterface

// File: rtl/gameover_lives_controller.sv
// rtl/gameover_lives_controller.sv - frame-synchronous play/miss/game-over controller with life counter and overlay
module gameover_lives_controller #(
  parameter int          HRES          = 1280,
  parameter int          VRES          = 720,
  parameter int          PADDLE_H      = 20,
  parameter int          NUM_OBJ       = 4,
  parameter int          LIVES         = 3,
  parameter int          MISS_PAUSE    = 32,
  parameter int          RESTART_PAUSE = 128,
  parameter int          BANNER_H      = 200,
  parameter int          BANNER_VSTART = (VRES - BANNER_H) >> 1,
  parameter logic [23:0] COLOR_GMO     = 24'hDD4F83,
  parameter logic [23:0] COLOR_MISS    = 24'hFF0000
) (
  input  logic                          pixel_clk,
  input  logic                          rst,
  gameover_lives_controller_if.slave    pix
);

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    MISS = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int          CHECK_ROW    = VRES - PADDLE_H;
  localparam int          BANNER_VEND  = BANNER_VSTART + BANNER_H;
  localparam int          HW           = $clog2(HRES);
  localparam logic [7:0]  MISS_LAST    = 8'(MISS_PAUSE - 1);
  localparam logic [7:0]  RESTART_LAST = 8'(RESTART_PAUSE - 1);
  localparam logic [3:0]  LIVES_INIT   = 4'(LIVES);

  state_t             state_q, state_d;
  logic [3:0]         lives_q, lives_d;
  logic [7:0]         pause_q, pause_d;
  logic [NUM_OBJ-1:0] passing_q, passing_d;
  logic [NUM_OBJ-1:0] caught_q, caught_d;
  logic               game_over_q, game_over_d;

  int                 hpos_i;
  int                 vpos_i;
  logic               miss_frame;
  logic               row_bit;
  logic               banner_on;
  logic               blink_on;
  logic [23:0]        color;

  assign hpos_i     = int'(pix.hpos);
  assign vpos_i     = int'(pix.vpos);
  // Any object that crossed the check row without touching the paddle is a miss.
  assign miss_frame = |(passing_q & ~caught_q);

  // Next-state: flag capture on the check row in PLAY, all transitions on fsync.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    pause_d     = pause_q;
    passing_d   = passing_q;
    caught_d    = caught_q;
    if (pix.fsync) begin
      passing_d = '0;
      caught_d  = '0;
      case (state_q)
        PLAY: begin
          if (miss_frame) begin
            lives_d = lives_q - 4'd1;
            pause_d = 8'd0;
            state_d = (lives_q == 4'd1) ? OVER : MISS;
          end
        end
        MISS: begin
          if (pause_q == MISS_LAST) begin
            state_d = PLAY;
            pause_d = 8'd0;
          end else begin
            pause_d = pause_q + 8'd1;
          end
        end
        OVER: begin
          if (pause_q == RESTART_LAST) begin
            state_d = PLAY;
            lives_d = LIVES_INIT;
            pause_d = 8'd0;
          end else begin
            pause_d = pause_q + 8'd1;
          end
        end
        default: state_d = PLAY;
      endcase
    end else if (state_q == PLAY && vpos_i == CHECK_ROW) begin
      passing_d = passing_q | pix.active_obj;
      caught_d  = caught_q | (pix.active_obj & {NUM_OBJ{pix.active_paddle}});
    end
    game_over_d = (state_d == OVER);
  end

  // State register; reset restores a fresh game with no pending flags.
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q     <= PLAY;
      lives_q     <= LIVES_INIT;
      pause_q     <= 8'd0;
      passing_q   <= '0;
      caught_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      pause_q     <= pause_d;
      passing_q   <= passing_d;
      caught_q    <= caught_d;
      game_over_q <= game_over_d;
    end
  end

  // Overlay selection: banner in OVER, paddle blink during the lit half of each 8-frame MISS cycle.
  always_comb begin
    row_bit = 1'b0;
    if (hpos_i >= 0 && hpos_i < HRES) begin
      row_bit = pix.banner_row[pix.hpos[HW-1:0]];
    end
    banner_on = (state_q == OVER) && (vpos_i >= BANNER_VSTART) && (vpos_i < BANNER_VEND) && row_bit;
    blink_on  = (state_q == MISS) && !pause_q[2] && pix.active_paddle;
    if (banner_on) begin
      color = COLOR_GMO;
    end else if (blink_on) begin
      color = COLOR_MISS;
    end else begin
      color = 24'h000000;
    end
    pix.pixel_overlay[2] = color[23:16];
    pix.pixel_overlay[1] = color[15:8];
    pix.pixel_overlay[0] = color[7:0];
    pix.use_overlay      = game_over_q | blink_on;
  end

  assign pix.banner_addr = 8'(pix.vpos - 12'(BANNER_VSTART));
  assign pix.lives       = lives_q;
  assign pix.state       = state_q;
  assign pix.game_over   = game_over_q;

endmodule

// File: tb/tb_gameover_lives_controller.sv
// tb/tb_gameover_lives_controller.sv - self-checking bench for gameover_lives_controller
module tb_gameover_lives_controller;

  logic pixel_clk = 1'b0;
  logic rst;
  logic [1279:0] row;

  gameover_lives_controller_if #(.NUM_OBJ(4), .HRES(1280)) bus ();

  gameover_lives_controller dut (
    .pixel_clk (pixel_clk),
    .rst       (rst),
    .pix       (bus)
  );

  assign bus.banner_row = row;

  always #5 pixel_clk = ~pixel_clk;

  int checks   = 0;
  int failures = 0;

  // Reference game: mode 0=PLAY 1=MISS 2=OVER, frames = fsyncs seen since entering the mode.
  int m_state, m_lives, m_frames;
  bit seen [4];
  bit hit  [4];

  logic [23:0] last_rgb;
  logic        last_use;

  typedef struct {
    bit         fs;
    logic [3:0] obj;
    bit         pad;
    int         h;
    int         v;
    int         st;
    int         lv;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int h, input int v, input bit pad);
    if (m_state == 2 && v >= 260 && v < 460 && h >= 0 && h < 1280 && row[h])
      return 24'hDD4F83;
    if (m_state == 1 && (m_frames % 8) < 4 && pad)
      return 24'hFF0000;
    return 24'h000000;
  endfunction

  function automatic bit exp_use(input bit pad);
    return (m_state == 2) || (m_state == 1 && (m_frames % 8) < 4 && pad);
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_lives  = 3;
    m_frames = 0;
    foreach (seen[i]) begin
      seen[i] = 0;
      hit[i]  = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit fs, input logic [3:0] obj, input bit pad, input int v);
    int missed;
    if (r) begin
      model_reset();
    end else if (fs) begin
      missed = 0;
      foreach (seen[i]) if (seen[i] && !hit[i]) missed++;
      if (m_state == 0) begin
        if (missed > 0) begin
          m_lives  = m_lives - 1;
          m_frames = 0;
          m_state  = (m_lives == 0) ? 2 : 1;
        end
      end else begin
        m_frames++;
        if (m_state == 1 && m_frames == 32) begin
          m_state  = 0;
          m_frames = 0;
        end else if (m_state == 2 && m_frames == 128) begin
          m_state  = 0;
          m_lives  = 3;
          m_frames = 0;
        end
      end
      foreach (seen[i]) begin
        seen[i] = 0;
        hit[i]  = 0;
      end
    end else if (m_state == 0 && v == 700) begin
      foreach (seen[i]) begin
        if (obj[i]) begin
          seen[i] = 1;
          if (pad) hit[i] = 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit fs, input logic [3:0] obj, input bit pad, input int h, input int v);
    rst               = r;
    bus.fsync         = fs;
    bus.active_obj    = obj;
    bus.active_paddle = pad;
    bus.hpos          = 12'(h);
    bus.vpos          = 12'(v);
    #1;
    last_rgb = {bus.pixel_overlay[2], bus.pixel_overlay[1], bus.pixel_overlay[0]};
    last_use = bus.use_overlay;
    chk("use_overlay", 32'(last_use), 32'(exp_use(pad)));
    chk("pixel_overlay", 32'(last_rgb), 32'(exp_rgb(h, v, pad)));
    chk("banner_addr", 32'(bus.banner_addr), 32'((v - 260) & 255));
    model_step(r, fs, obj, pad, v);
    @(posedge pixel_clk);
    #1;
    chk("state", 32'(bus.state), 32'(m_state));
    chk("lives", 32'(bus.lives), 32'(m_lives));
    chk("game_over", 32'(bus.game_over), 32'(m_state == 2));
  endtask

  task automatic lose_life();
    cyc(0, 0, 4'b0010, 0, 600, 700);
    cyc(0, 1, 4'b0000, 0, 0, 0);
    if (m_state == 1) repeat (32) cyc(0, 1, 4'b0000, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 1280; i++) row[i] = 1'($urandom_range(0, 1));
    row[5] = 1'b1;

    tbl[0] = '{fs:1, obj:4'b0001, pad:0, h:600, v:700, st:0, lv:3};
    tbl[1] = '{fs:1, obj:4'b0000, pad:0, h:0,   v:0,   st:0, lv:3};
    tbl[2] = '{fs:0, obj:4'b0001, pad:1, h:600, v:700, st:0, lv:3};
    tbl[3] = '{fs:0, obj:4'b0001, pad:0, h:620, v:700, st:0, lv:3};
    tbl[4] = '{fs:1, obj:4'b0000, pad:0, h:0,   v:0,   st:0, lv:3};
    tbl[5] = '{fs:0, obj:4'b0010, pad:0, h:300, v:700, st:0, lv:3};
    tbl[6] = '{fs:1, obj:4'b0000, pad:0, h:0,   v:0,   st:1, lv:2};

    rst = 1'b1;
    bus.fsync = 1'b0;
    bus.active_obj = '0;
    bus.active_paddle = 1'b0;
    bus.hpos = '0;
    bus.vpos = '0;
    @(posedge pixel_clk);
    #1;
    model_reset();
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_lives", 32'(bus.lives), 32'd3);
    chk("reset_game_over", 32'(bus.game_over), 32'd0);
    chk("reset_use_overlay", 32'(bus.use_overlay), 32'd0);

    // Catch, fsync-coincident pixel, single miss
    foreach (tbl[i]) begin
      cyc(0, tbl[i].fs, tbl[i].obj, tbl[i].pad, tbl[i].h, tbl[i].v);
      chk("tbl_state", 32'(bus.state), 32'(tbl[i].st));
      chk("tbl_lives", 32'(bus.lives), 32'(tbl[i].lv));
    end

    // MISS: blink pattern, suppressed miss, exact 32-frame length
    for (int k = 0; k < 32; k++) begin
      cyc(0, 0, 4'b0000, 1, 100, 700);
      chk("blink_use", 32'(last_use), 32'((k % 8) < 4));
      chk("blink_rgb", 32'(last_rgb), ((k % 8) < 4) ? 32'hFF0000 : 32'h0);
      if (k == 3) cyc(0, 0, 4'b0010, 0, 600, 700);
      cyc(0, 1, 4'b0000, 0, 0, 0);
      chk("miss_len_state", 32'(bus.state), (k < 31) ? 32'd1 : 32'd0);
    end
    chk("miss_suppressed_lives", 32'(bus.lives), 32'd2);

    // Two objects missed in one frame cost one life
    cyc(0, 0, 4'b0101, 0, 600, 700);
    cyc(0, 1, 4'b0000, 0, 0, 0);
    chk("double_miss_lives", 32'(bus.lives), 32'd1);
    chk("double_miss_state", 32'(bus.state), 32'd1);
    repeat (32) cyc(0, 1, 4'b0000, 0, 0, 0);
    chk("back_to_play", 32'(bus.state), 32'd0);

    // Last life lost -> OVER with banner
    lose_life();
    chk("over_lives", 32'(bus.lives), 32'd0);
    chk("over_flag", 32'(bus.game_over), 32'd1);
    cyc(0, 0, 4'b0000, 0, 5, 260);
    chk("banner_rgb", 32'(last_rgb), 32'hDD4F83);
    chk("banner_use", 32'(last_use), 32'd1);
    chk("banner_addr0", 32'(bus.banner_addr), 32'd0);
    cyc(0, 0, 4'b0000, 0, -3, 300);
    chk("banner_neg_h", 32'(last_rgb), 32'h0);
    cyc(0, 0, 4'b0000, 0, 1300, 300);
    chk("banner_big_h", 32'(last_rgb), 32'h0);
    cyc(0, 0, 4'b0000, 0, 5, 459);
    cyc(0, 0, 4'b0000, 0, 5, 460);
    chk("banner_below", 32'(last_rgb), 32'h0);
    cyc(0, 0, 4'b0000, 0, 5, 259);
    chk("banner_above", 32'(last_rgb), 32'h0);
    cyc(0, 0, 4'b0001, 0, 600, 700);
    for (int k = 0; k < 128; k++) begin
      cyc(0, 1, 4'b0000, 0, 0, 0);
      chk("over_len_state", 32'(bus.state), (k < 127) ? 32'd2 : 32'd0);
    end
    chk("restart_lives", 32'(bus.lives), 32'd3);
    chk("restart_game_over", 32'(bus.game_over), 32'd0);

    // Reset in the middle of OVER, then reset over a pending miss flag
    lose_life();
    lose_life();
    lose_life();
    repeat (50) cyc(0, 1, 4'b0000, 0, 0, 0);
    chk("mid_over_state", 32'(bus.state), 32'd2);
    cyc(0, 0, 4'b0000, 0, 5, 260);
    cyc(1, 0, 4'b0000, 0, 5, 260);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_lives", 32'(bus.lives), 32'd3);
    chk("rst_game_over", 32'(bus.game_over), 32'd0);
    cyc(0, 0, 4'b1000, 0, 600, 700);
    cyc(1, 0, 4'b0000, 0, 0, 0);
    cyc(0, 1, 4'b0000, 0, 0, 0);
    cyc(0, 1, 4'b0000, 0, 0, 0);
    chk("stale_flag_state", 32'(bus.state), 32'd0);
    chk("stale_flag_lives", 32'(bus.lives), 32'd3);

    // Random play against the reference model
    for (int n = 0; n < 6000; n++) begin
      int v;
      int h;
      case ($urandom_range(0, 3))
        0, 1:    v = 700;
        2:       v = int'($urandom_range(250, 470));
        default: v = int'($urandom_range(0, 719));
      endcase
      h = int'($urandom_range(0, 1310)) - 5;
      cyc(($urandom_range(0, 1999) == 0), ($urandom_range(0, 4) == 0),
          4'($urandom), 1'($urandom), h, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
